// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared definitions for the seven-segment scan controller.
//                Scan FSM state encoding and the decoder code width.
//  Revision    : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

    // Width of one digit code fed to the external 4-to-7 decoder.
    localparam int SEG_CODE_W = 4;

    // Scan FSM state encoding.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SHOW = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_SHOW = c_ST_SHOW,
        ST_GAP  = c_ST_GAP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seven_seg_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_tick_counter
//  Description : Clearable up-counter with a terminal-count flag. The flag is
//                high while the count equals i_last_val, so a phase lasting N
//                cycles is timed by passing N-1 and clearing on the phase
//                change.
//  Ports       : clk, rst      clock / synchronous active-high reset
//                i_clear       restart the count at 0 on the next edge
//                i_last_val    terminal count value for the current phase
//                o_last        count has reached i_last_val
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_tick_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_last_val,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_last = (r_count == i_last_val);

endmodule
`default_nettype wire

// File: rtl/seven_segment_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scan_ctrl
//  Description : Time-multiplexes one shared 4-bit-to-7-segment decoder over
//                NUM_DIGITS common-select digits. Each digit is lit for
//                DIV_COUNT cycles followed by BLANK_CYCLES of all-dark gap.
//                New digit values are double-buffered and committed only at
//                frame boundaries so a frame never mixes old and new values.
//  Ports       : clk, rst      clock / synchronous active-high reset
//                enable        1 = scanning, 0 = display dark
//                load          strobe: capture digits_in/blank_mask to shadow
//                digits_in     digit k code at [4k+3:4k], digit 0 rightmost
//                blank_mask    bit k forces digit k dark
//                dec_code      code to the external decoder
//                digit_en      one-hot active-high digit select
//                scan_idx      index of digit being / next to be lit
//                frame_done    1-cycle pulse on each wrapped frame start
//  Revision    : 1.0  initial release
// ============================================================================
module seven_segment_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_COUNT    = 50000,
    parameter int BLANK_CYCLES = 8,
    parameter int CNT_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            load,
    input  logic [4*NUM_DIGITS-1:0]         digits_in,
    input  logic [NUM_DIGITS-1:0]           blank_mask,
    output logic [3:0]                      dec_code,
    output logic [NUM_DIGITS-1:0]           digit_en,
    output logic [$clog2(NUM_DIGITS)-1:0]   scan_idx,
    output logic                            frame_done
);

    localparam int                    c_IDX_W     = $clog2(NUM_DIGITS);
    localparam int                    c_IMG_W     = SEG_CODE_W * NUM_DIGITS;
    localparam logic [CNT_W-1:0]      c_SHOW_LAST = CNT_W'(DIV_COUNT - 1);
    // Unused when BLANK_CYCLES is 0 because GAP is never entered then.
    localparam logic [CNT_W-1:0]      c_GAP_LAST  =
        CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [c_IDX_W-1:0]    c_IDX_MAX   = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_ONE       = NUM_DIGITS'(1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_IDX_W-1:0]        w_idx_next;
    logic [c_IDX_W-1:0]        w_idx_inc;
    logic                      w_wrap;

    logic                      w_cnt_clear;
    logic                      w_cnt_last;
    logic [CNT_W-1:0]          w_cnt_last_val;
    logic                      w_boundary;

    logic [c_IMG_W-1:0]        r_shadow_digits;
    logic [NUM_DIGITS-1:0]     r_shadow_mask;
    logic                      r_pending;
    logic [c_IMG_W-1:0]        r_disp_digits;
    logic [NUM_DIGITS-1:0]     r_disp_mask;
    logic [c_IMG_W-1:0]        w_disp_digits_next;
    logic [NUM_DIGITS-1:0]     w_disp_mask_next;

    logic [SEG_CODE_W-1:0]     r_dec_code;
    logic [SEG_CODE_W-1:0]     w_dec_code_next;
    logic [NUM_DIGITS-1:0]     r_digit_en;
    logic [NUM_DIGITS-1:0]     w_digit_en_next;
    logic                      r_frame_done;
    logic                      w_frame_done_next;

    // ------------------------------------------------------------------
    // Phase timer: one counter serves both SHOW and GAP durations.
    // ------------------------------------------------------------------
    assign w_cnt_last_val = (r_state == ST_GAP) ? c_GAP_LAST : c_SHOW_LAST;

    seven_seg_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cnt_clear),
        .i_last_val (w_cnt_last_val),
        .o_last     (w_cnt_last)
    );

    assign w_wrap    = (r_idx == c_IDX_MAX);
    assign w_idx_inc = w_wrap ? '0 : (r_idx + c_IDX_W'(1));

    // ------------------------------------------------------------------
    // Next-state logic. A boundary is either the IDLE->SHOW entry or the
    // wrap back to digit 0; only the wrap raises frame_done.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_cnt_clear       = 1'b0;
        w_boundary        = 1'b0;
        w_frame_done_next = 1'b0;

        if (!enable) begin
            w_state_next = ST_IDLE;
            w_idx_next   = '0;
            w_cnt_clear  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_SHOW;
                    w_idx_next   = '0;
                    w_cnt_clear  = 1'b1;
                    w_boundary   = 1'b1;
                end
                ST_SHOW: begin
                    if (w_cnt_last) begin
                        w_cnt_clear = 1'b1;
                        if (BLANK_CYCLES == 0) begin
                            w_idx_next        = w_idx_inc;
                            w_boundary        = w_wrap;
                            w_frame_done_next = w_wrap;
                        end else begin
                            w_state_next = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_cnt_last) begin
                        w_state_next      = ST_SHOW;
                        w_idx_next        = w_idx_inc;
                        w_cnt_clear       = 1'b1;
                        w_boundary        = w_wrap;
                        w_frame_done_next = w_wrap;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                    w_cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output precompute. Outputs are registered, so they are derived from
    // the next state and the post-commit display image; the first cycle
    // of a new frame therefore already shows the freshly committed value.
    // ------------------------------------------------------------------
    always_comb begin
        w_disp_digits_next = r_disp_digits;
        w_disp_mask_next   = r_disp_mask;
        if (w_boundary && r_pending) begin
            w_disp_digits_next = r_shadow_digits;
            w_disp_mask_next   = r_shadow_mask;
        end

        w_digit_en_next = '0;
        w_dec_code_next = r_dec_code;
        if (w_state_next == ST_SHOW) begin
            w_dec_code_next = w_disp_digits_next[w_idx_next*SEG_CODE_W +: SEG_CODE_W];
            if (!w_disp_mask_next[w_idx_next]) begin
                w_digit_en_next = c_ONE << w_idx_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_dec_code   <= '0;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_dec_code   <= w_dec_code_next;
            r_digit_en   <= w_digit_en_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. A load coinciding with a boundary commits the old
    // shadow first and leaves the new value pending for the next frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_digits <= '0;
            r_shadow_mask   <= '0;
            r_pending       <= 1'b0;
            r_disp_digits   <= '0;
            r_disp_mask     <= '0;
        end else begin
            r_disp_digits <= w_disp_digits_next;
            r_disp_mask   <= w_disp_mask_next;
            if (load) begin
                r_shadow_digits <= digits_in;
                r_shadow_mask   <= blank_mask;
                r_pending       <= 1'b1;
            end else if (w_boundary) begin
                r_pending       <= 1'b0;
            end
        end
    end

    assign dec_code   = r_dec_code;
    assign digit_en   = r_digit_en;
    assign scan_idx   = r_idx;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_segment_scan_ctrl
//  Description : Scoreboard bench for seven_segment_scan_ctrl. Two instances
//                share the inputs: A (4 digits, 4 lit, 2 gap) and B (4 digits,
//                1 lit, no gap). A timeline model computes expected outputs
//                from the position inside the frame period.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_segment_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  blank_mask;

    logic [3:0]  a_dec_code, b_dec_code;
    logic [3:0]  a_digit_en, b_digit_en;
    logic [1:0]  a_scan_idx, b_scan_idx;
    logic        a_frame_done, b_frame_done;

    typedef struct packed {
        logic [3:0] dec;
        logic [3:0] en;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    typedef struct {
        bit          running;
        int          pos;
        logic [15:0] shadow;
        logic [15:0] disp;
        logic [3:0]  smask;
        logic [3:0]  dmask;
        logic [3:0]  code;
        bit          pending;
    } mdl_t;

    exp_t qa[$];
    exp_t qb[$];
    mdl_t ma;
    mdl_t mb;
    exp_t ea;
    exp_t eb;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seven_segment_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DIV_COUNT    (4),
        .BLANK_CYCLES (2),
        .CNT_W        (16)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .blank_mask (blank_mask),
        .dec_code   (a_dec_code),
        .digit_en   (a_digit_en),
        .scan_idx   (a_scan_idx),
        .frame_done (a_frame_done)
    );

    seven_segment_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DIV_COUNT    (1),
        .BLANK_CYCLES (0),
        .CNT_W        (16)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .blank_mask (blank_mask),
        .dec_code   (b_dec_code),
        .digit_en   (b_digit_en),
        .scan_idx   (b_scan_idx),
        .frame_done (b_frame_done)
    );

    // Reference model: position within the frame determines everything.
    task automatic step(inout mdl_t m, input int dv, input int bl,
                        input bit r, input bit en, input bit ld,
                        input logic [15:0] d, input logic [3:0] mk,
                        output exp_t e);
        int slot_len;
        int period;
        int slot;
        int off;
        bit boundary;
        slot_len = dv + bl;
        period   = slot_len * 4;
        boundary = 1'b0;
        e        = '0;
        if (r) begin
            m.running = 1'b0; m.pos = 0; m.shadow = '0; m.disp = '0;
            m.smask = '0; m.dmask = '0; m.code = '0; m.pending = 1'b0;
        end else begin
            if (!en) begin
                m.running = 1'b0;
                m.pos     = 0;
            end else if (!m.running) begin
                m.running = 1'b1;
                m.pos     = 0;
                boundary  = 1'b1;
            end else begin
                m.pos = (m.pos + 1) % period;
                if (m.pos == 0) begin
                    boundary = 1'b1;
                    e.fd     = 1'b1;
                end
            end
            if (boundary && m.pending) begin
                m.disp    = m.shadow;
                m.dmask   = m.smask;
                m.pending = 1'b0;
            end
            if (ld) begin
                m.shadow  = d;
                m.smask   = mk;
                m.pending = 1'b1;
            end
            if (m.running) begin
                slot  = m.pos / slot_len;
                off   = m.pos % slot_len;
                e.idx = slot[1:0];
                if (off < dv) begin
                    m.code = m.disp[slot*4 +: 4];
                    if (!m.dmask[slot]) e.en = 4'b0001 << slot;
                end
            end
        end
        e.dec = m.code;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the expected
    // outputs that will appear after the following rising edge.
    task automatic cyc(input bit r, input bit en, input bit ld,
                       input logic [15:0] d, input logic [3:0] mk);
        exp_t e;
        @(negedge clk);
        rst = r; enable = en; load = ld; digits_in = d; blank_mask = mk;
        step(ma, 4, 2, r, en, ld, d, mk, e);
        qa.push_back(e);
        step(mb, 1, 0, r, en, ld, d, mk, e);
        qb.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, compare one entry per edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                chk("A.dec_code",   32'(a_dec_code),   32'(ea.dec));
                chk("A.digit_en",   32'(a_digit_en),   32'(ea.en));
                chk("A.scan_idx",   32'(a_scan_idx),   32'(ea.idx));
                chk("A.frame_done", 32'(a_frame_done), 32'(ea.fd));
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                chk("B.dec_code",   32'(b_dec_code),   32'(eb.dec));
                chk("B.digit_en",   32'(b_digit_en),   32'(eb.en));
                chk("B.scan_idx",   32'(b_scan_idx),   32'(eb.idx));
                chk("B.frame_done", 32'(b_frame_done), 32'(eb.fd));
            end
        end
    end

    initial begin
        bit          r_r;
        bit          r_en;
        bit          r_ld;
        logic [3:0]  r_mk;
        rst = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0; blank_mask = '0;

        // Reset, then load an image while idle and start scanning.
        cyc(1, 0, 0, 16'h0000, 4'h0);
        cyc(1, 0, 0, 16'h0000, 4'h0);
        cyc(0, 0, 1, 16'h4321, 4'h0);
        repeat (8) cyc(0, 1, 0, 16'h0000, 4'h0);
        // Load while digit 1 is lit: this frame must keep the old image.
        cyc(0, 1, 1, 16'h8765, 4'h0);
        repeat (50) cyc(0, 1, 0, 16'h0000, 4'h0);
        // Blank digit 3.
        cyc(0, 1, 1, 16'h8765, 4'b1000);
        repeat (30) cyc(0, 1, 0, 16'h0000, 4'h0);
        // Drop enable in the middle of digit 2, then restart.
        cyc(0, 0, 0, 16'h0000, 4'h0);
        repeat (14) cyc(0, 1, 0, 16'h0000, 4'h0);
        cyc(0, 0, 0, 16'h0000, 4'h0);
        repeat (30) cyc(0, 1, 0, 16'h0000, 4'h0);
        // Back-to-back loads: the last one wins.
        cyc(0, 1, 1, 16'h1111, 4'h0);
        cyc(0, 1, 1, 16'hABCD, 4'h0);
        repeat (30) cyc(0, 1, 0, 16'h0000, 4'h0);
        // Pending load then reset mid-scan: pending must be discarded.
        cyc(0, 1, 1, 16'h9999, 4'h0);
        cyc(1, 1, 0, 16'h0000, 4'h0);
        repeat (20) cyc(0, 1, 0, 16'h0000, 4'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r_r  = ($urandom_range(0, 299) == 0);
            r_en = ($urandom_range(0, 99) != 0);
            r_ld = ($urandom_range(0, 19) == 0);
            r_mk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cyc(r_r, r_en, r_ld, 16'($urandom), r_mk);
        end

        repeat (3) @(negedge clk);
        chk("A.queue_drained", 32'(qa.size()), 32'd0);
        chk("B.queue_drained", 32'(qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
